mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequencer for the multiply/divide unit (MDU) in the P7 pipeline.
- Accepts E-stage MDU operations using the 4-bit MDUOp encoding produced by the decoder.
- Models the multi-cycle busy window, owns the HI/LO architectural registers, returns mfhi/mflo data to E, and raises the D-stage stall request for MDU structural hazards.
- Honours exception/interrupt cancellation of the E-stage instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- E_MDUOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
- E_start  input  1  E-stage start flag; only meaningful with MDUOp 1-4
- E_A  input  32  rs operand, forwarded
- E_B  input  32  rt operand, forwarded
- D_MDUOp  input  4  D-stage op, same encoding; used for the stall decision
- Req  input  1  exception/interrupt flush: E-stage instruction is cancelled this cycle
- E_MDUOut  output  32  HI for op 5, LO for op 6, else 0 (combinational)
- busy  output  1  a mult/div is in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- stall_MDU  output  1  hold D and bubble E

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state IDLE, counter 0, busy 0, HI 0, LO 0, pending results 0.
- reset overrides every other input, including mid-operation: the in-flight op is discarded and HI/LO clear to 0.
- Effective start: eff_start = E_start & (E_MDUOp in 1..4) & ~Req & (state==IDLE).
  - eff_start while BUSY cannot occur, because stall_MDU prevents it.
  - If it does occur, it is ignored; assertion in the bench.
- States:
  - IDLE:
    - On eff_start at edge T: compute the result into pending_hi/pending_lo, load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES), go to BUSY.
    - busy=1 for cycles T+1 .. T+N.
  - BUSY:
    - Each edge: if counter==0, commit pending to HI/LO and go to IDLE; else decrement counter.
    - New HI/LO values are visible in cycle T+N+1, together with busy=0.
- Arithmetic:
  - mult: signed 64-bit product; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product; same split.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero: still busy for DIV_CYCLES, but HI and LO remain unchanged at commit.
  - Signed overflow 0x80000000/-1: LO=0x80000000, HI=0.
- mthi/mtlo:
  - Written at the edge of the cycle they are in E, if ~Req and state==IDLE.
  - Take effect immediately (one-cycle op, no busy).
  - With Req=1 they do not write.
- Req:
  - Cancels only an op that is in E this cycle (start, mthi, mtlo).
  - An already-started op keeps counting and commits normally; it belongs to an older, committed instruction.
- stall_MDU = (D_MDUOp in 1..8) & (busy | (E_start & E_MDUOp in 1..4)).
  - It does not depend on Req.
  - The pipeline's existing Req flush takes priority over stall.
- E_MDUOut returns HI/LO as currently registered. Reads in E cannot overlap busy, because of the stall.
- Commit and mthi/mtlo in the same edge: impossible, since mthi requires IDLE.

Test Plan:
- mult: A=0xFFFFFFFE, B=3, start at edge T -> busy=1 for T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6; busy=0.
- divu then stall: A=100, B=7; D_MDUOp=6 during busy -> stall_MDU=1 for 10 cycles; after release, mflo gives 14 and HI=2. div with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: HI=0x11, LO=0x22 preset via mthi/mtlo; divu by 0 -> busy 10 cycles, HI/LO unchanged.
- Req cancel: mult start with Req=1 -> busy stays 0, HI/LO unchanged. mtlo 0xABCD with Req=1 -> LO unchanged. Then mult started one cycle before a Req -> completes and commits.
- Reset mid-op: reset at BUSY cycle 3 -> next cycle busy=0, HI=LO=0; no commit afterwards.
- Back-to-back: mthi 5 then mfhi in the next cycle -> E_MDUOut=5, no stall. mult followed immediately by mult in D -> stall_MDU=1 in the start cycle and for 5 busy cycles.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit sequencer for the P7 pipeline.
// Owns the HI/LO registers, models the multi-cycle busy window of
// mult/div, serves mfhi/mflo reads to E and raises the D-stage stall
// for MDU structural hazards. An E-stage flush (Req) cancels only the
// operation currently in E; an operation already started runs to commit.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic [3:0]  D_MDUOp,
    input  logic        Req,
    output logic [31:0] E_MDUOut,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        stall_MDU
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] pending_hi_r;
    logic [31:0] pending_lo_r;

    logic        e_muldiv_s;
    logic        d_mdu_s;
    logic        eff_start_s;
    logic        wr_hi_s;
    logic        wr_lo_s;
    logic [3:0]  load_cnt_s;
    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic        is_signed_div_s;
    logic [31:0] dvd_mag_s;
    logic [31:0] dvs_mag_s;
    logic [31:0] dvs_safe_s;
    logic [31:0] quo_mag_s;
    logic [31:0] rem_mag_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic [31:0] mdu_out_s;

    assign e_muldiv_s  = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
    assign d_mdu_s     = (D_MDUOp >= OP_MULT) && (D_MDUOp <= OP_MTLO);
    assign eff_start_s = E_start && e_muldiv_s && !Req && (state_r == IDLE);
    assign wr_hi_s     = (E_MDUOp == OP_MTHI) && !Req && (state_r == IDLE);
    assign wr_lo_s     = (E_MDUOp == OP_MTLO) && !Req && (state_r == IDLE);

    assign sprod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign uprod_s = {32'd0, E_A} * {32'd0, E_B};

    // Shared unsigned divider on magnitudes; signs are restored afterwards so
    // that 0x80000000 / -1 naturally yields LO=0x80000000, HI=0.
    always_comb begin
        is_signed_div_s = (E_MDUOp == OP_DIV);
        if (is_signed_div_s && E_A[31]) begin
            dvd_mag_s = 32'd0 - E_A;
        end else begin
            dvd_mag_s = E_A;
        end
        if (is_signed_div_s && E_B[31]) begin
            dvs_mag_s = 32'd0 - E_B;
        end else begin
            dvs_mag_s = E_B;
        end
        if (dvs_mag_s == 32'd0) begin
            dvs_safe_s = 32'd1;
        end else begin
            dvs_safe_s = dvs_mag_s;
        end
        quo_mag_s = dvd_mag_s / dvs_safe_s;
        rem_mag_s = dvd_mag_s % dvs_safe_s;
    end

    // Select the result captured at start; divide by zero keeps HI/LO as they are.
    always_comb begin
        res_hi_s   = hi_r;
        res_lo_s   = lo_r;
        load_cnt_s = DIV_LOAD;
        case (E_MDUOp)
            OP_MULT: begin
                res_hi_s   = sprod_s[63:32];
                res_lo_s   = sprod_s[31:0];
                load_cnt_s = MULT_LOAD;
            end
            OP_MULTU: begin
                res_hi_s   = uprod_s[63:32];
                res_lo_s   = uprod_s[31:0];
                load_cnt_s = MULT_LOAD;
            end
            OP_DIV: begin
                if (E_B == 32'd0) begin
                    res_hi_s = hi_r;
                    res_lo_s = lo_r;
                end else begin
                    res_lo_s = (E_A[31] ^ E_B[31]) ? (32'd0 - quo_mag_s) : quo_mag_s;
                    res_hi_s = E_A[31] ? (32'd0 - rem_mag_s) : rem_mag_s;
                end
            end
            OP_DIVU: begin
                if (E_B == 32'd0) begin
                    res_hi_s = hi_r;
                    res_lo_s = lo_r;
                end else begin
                    res_lo_s = quo_mag_s;
                    res_hi_s = rem_mag_s;
                end
            end
            default: begin
                res_hi_s   = hi_r;
                res_lo_s   = lo_r;
                load_cnt_s = DIV_LOAD;
            end
        endcase
    end

    // Sequencer: start/busy countdown/commit, plus direct mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            busy_r       <= 1'b0;
            hi_r         <= 32'd0;
            lo_r         <= 32'd0;
            pending_hi_r <= 32'd0;
            pending_lo_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (eff_start_s) begin
                        pending_hi_r <= res_hi_s;
                        pending_lo_r <= res_lo_s;
                        cnt_r        <= load_cnt_s;
                        busy_r       <= 1'b1;
                        state_r      <= BUSY;
                    end else if (wr_hi_s) begin
                        hi_r <= E_A;
                    end else if (wr_lo_s) begin
                        lo_r <= E_A;
                    end
                end
                BUSY: begin
                    if (cnt_r == 4'd0) begin
                        hi_r    <= pending_hi_r;
                        lo_r    <= pending_lo_r;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // mfhi/mflo read path back to E; anything else reads as zero.
    always_comb begin
        case (E_MDUOp)
            OP_MFHI: mdu_out_s = hi_r;
            OP_MFLO: mdu_out_s = lo_r;
            default: mdu_out_s = 32'd0;
        endcase
    end

    assign E_MDUOut  = mdu_out_s;
    assign busy      = busy_r;
    assign HI        = hi_r;
    assign LO        = lo_r;
    assign stall_MDU = d_mdu_s && (busy_r || (E_start && e_muldiv_s));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a result scoreboard is filled when a
// mult/div is started and drained when busy falls.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic        E_start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic [3:0]  D_MDUOp;
    logic        Req;
    logic [31:0] E_MDUOut;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        stall_MDU;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb_q[$];
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_start(E_start),
        .E_A(E_A), .E_B(E_B), .D_MDUOp(D_MDUOp), .Req(Req),
        .E_MDUOut(E_MDUOut), .busy(busy), .HI(HI), .LO(LO), .stall_MDU(stall_MDU)
    );

    always #5 clk = ~clk;

    // A new mult/div must never be presented while the unit is busy.
    always @(negedge clk) begin
        if (!reset && busy && E_start && (E_MDUOp inside {[4'd1:4'd4]}))
            $error("eff_start presented while busy");
    end

    function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] h,
                                   input logic [31:0] l);
        res_t   r;
        longint sa, sb, q, m;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.hi = h;
        r.lo = l;
        case (op)
            4'd1: begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            4'd3: if (b != 32'd0) begin
                q = sa / sb; m = sa % sb; r.hi = m[31:0]; r.lo = q[31:0];
            end
            4'd4: if (b != 32'd0) begin r.hi = a % b; r.lo = a / b; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        E_MDUOp = 4'd0; E_start = 1'b0; E_A = 32'd0; E_B = 32'd0;
        D_MDUOp = 4'd0; Req = 1'b0;
    endtask

    // Start a mult/div, check busy length and stall, then check the commit.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] dop, input int n);
        int   cyc;
        logic exp_stall;
        res_t got;
        exp_stall = (dop >= 4'd1) && (dop <= 4'd8);
        E_MDUOp = op; E_start = 1'b1; E_A = a; E_B = b; D_MDUOp = dop; Req = 1'b0;
        #1;
        checks++;
        if (stall_MDU !== exp_stall) begin
            errors++;
            $display("FAIL %s start-stall got=%b exp=%b", nm, stall_MDU, exp_stall);
        end
        sb_q.push_back(model(op, a, b, exp_hi, exp_lo));
        step();
        E_MDUOp = 4'd0; E_start = 1'b0;
        #1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 20) begin
            checks++;
            if (stall_MDU !== exp_stall) begin
                errors++;
                $display("FAIL %s busy-stall cyc=%0d got=%b exp=%b", nm, cyc, stall_MDU, exp_stall);
            end
            cyc++;
            step();
        end
        checks++;
        if (cyc != n) begin
            errors++;
            $display("FAIL %s busy-cycles got=%0d exp=%0d", nm, cyc, n);
        end
        got = sb_q.pop_front();
        exp_hi = got.hi;
        exp_lo = got.lo;
        checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL %s commit HI=%h LO=%h exp HI=%h LO=%h", nm, HI, LO, exp_hi, exp_lo);
        end
        D_MDUOp = 4'd0;
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] v, input logic rq);
        E_MDUOp = op; E_A = v; Req = rq;
        step();
        if (!rq && op == 4'd7) exp_hi = v;
        if (!rq && op == 4'd8) exp_lo = v;
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || stall_MDU !== 1'b0 || E_MDUOut !== 32'd0) begin
            errors++;
            $display("FAIL reset busy=%b HI=%h LO=%h stall=%b out=%h exp 0", busy, HI, LO, stall_MDU, E_MDUOut);
        end
    endtask

    task automatic test_mult();
        run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 4'd0, MC);
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mult_const HI=%h LO=%h exp FFFFFFFF FFFFFFFA", HI, LO);
        end
        run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 4'd0, MC);
        for (int i = 0; i < 3; i++) begin
            run_op("mult_rnd", 4'd1, $urandom, $urandom, 4'd0, MC);
            run_op("multu_rnd", 4'd2, $urandom, $urandom, 4'd0, MC);
        end
    endtask

    task automatic test_div_stall();
        run_op("divu", 4'd4, 32'd100, 32'd7, 4'd6, DC);
        E_MDUOp = 4'd6;
        #1;
        checks++;
        if (E_MDUOut !== 32'd14 || HI !== 32'd2 || stall_MDU !== 1'b0) begin
            errors++;
            $display("FAIL mflo_after_divu out=%h HI=%h stall=%b exp 14 2 0", E_MDUOut, HI, stall_MDU);
        end
        idle_in();
        run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 4'd0, DC);
        checks++;
        if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_neg_const HI=%h LO=%h exp FFFFFFFF FFFFFFFD", HI, LO);
        end
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 4'd0, DC);
        checks++;
        if (LO !== 32'h80000000 || HI !== 32'd0) begin
            errors++;
            $display("FAIL div_ovf_const HI=%h LO=%h exp 0 80000000", HI, LO);
        end
        for (int i = 0; i < 3; i++) begin
            run_op("div_rnd", 4'd3, $urandom, $urandom_range(1, 1000) * (i == 1 ? -1 : 1), 4'd0, DC);
            run_op("divu_rnd", 4'd4, $urandom, $urandom_range(1, 100000), 4'd0, DC);
        end
    endtask

    task automatic test_div_zero();
        do_mt(4'd7, 32'h11, 1'b0);
        do_mt(4'd8, 32'h22, 1'b0);
        run_op("divu_zero", 4'd4, 32'd100, 32'd0, 4'd0, DC);
        checks++;
        if (HI !== 32'h11 || LO !== 32'h22) begin
            errors++;
            $display("FAIL divzero_const HI=%h LO=%h exp 11 22", HI, LO);
        end
        run_op("div_zero", 4'd3, 32'hFFFFFF00, 32'd0, 4'd0, DC);
    endtask

    task automatic test_req();
        E_MDUOp = 4'd1; E_start = 1'b1; E_A = 32'd9; E_B = 32'd9; Req = 1'b1;
        step();
        idle_in();
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL req_cancel_mult busy=%b HI=%h LO=%h exp 0 %h %h", busy, HI, LO, exp_hi, exp_lo);
        end
        do_mt(4'd8, 32'hABCD, 1'b1);
        #1;
        checks++;
        if (LO !== exp_lo) begin
            errors++;
            $display("FAIL req_cancel_mtlo LO=%h exp %h", LO, exp_lo);
        end
        // mult started, then a flush arrives in the following cycle
        E_MDUOp = 4'd1; E_start = 1'b1; E_A = 32'd1234; E_B = 32'd5678;
        sb_q.push_back(model(4'd1, 32'd1234, 32'd5678, exp_hi, exp_lo));
        step();
        idle_in();
        Req = 1'b1;
        step();
        Req = 1'b0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) step();
        begin
            res_t r;
            r = sb_q.pop_front();
            exp_hi = r.hi; exp_lo = r.lo;
        end
        checks++;
        if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL req_after_start busy=%b HI=%h LO=%h exp 0 %h %h", busy, HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset_mid();
        do_mt(4'd7, 32'h5555, 1'b0);
        do_mt(4'd8, 32'h6666, 1'b0);
        E_MDUOp = 4'd2; E_start = 1'b1; E_A = 32'd77; E_B = 32'd88;
        sb_q.push_back(model(4'd2, 32'd77, 32'd88, exp_hi, exp_lo));
        step();
        idle_in();
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        void'(sb_q.pop_front());
        exp_hi = 32'd0; exp_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b HI=%h LO=%h exp 0 0 0", busy, HI, LO);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_nocommit busy=%b HI=%h LO=%h exp 0 0 0", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        E_MDUOp = 4'd7; E_A = 32'd5; D_MDUOp = 4'd5;
        #1;
        checks++;
        if (stall_MDU !== 1'b0) begin
            errors++;
            $display("FAIL mthi_no_stall got=%b exp=0", stall_MDU);
        end
        step();
        exp_hi = 32'd5;
        E_MDUOp = 4'd5; E_A = 32'd0; D_MDUOp = 4'd0;
        #1;
        checks++;
        if (E_MDUOut !== 32'd5 || stall_MDU !== 1'b0) begin
            errors++;
            $display("FAIL mfhi_after_mthi out=%h stall=%b exp 5 0", E_MDUOut, stall_MDU);
        end
        idle_in();
        run_op("mult_b2b", 4'd1, 32'h0001_0000, 32'h0003_0000, 4'd1, MC);
        run_op("mult_b2b_2", 4'd1, 32'hFFFF_8000, 32'h7FFF_FFFF, 4'd8, MC);
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        test_reset();
        test_mult();
        test_div_stall();
        test_div_zero();
        test_req();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
